// File: rtl/image_loader.sv
// Streams a boot image into memory: a header word (initial PC/SP), a payload
// word count N, then N payload words written as words or as four byte writes.
module image_loader #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 1024,
    parameter int ADDR_W    = 12,
    parameter int BYTE_MODE = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] init_val_o,
    output logic              init_we_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, WORD, SPLIT, DONE, ERR} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        k_q, k_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [DATA_W-1:0] init_val_q, init_val_d;
    logic              init_we_q, init_we_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              xfer;
    logic              last;

    assign in_ready_o = state_q inside {HDR0, HDR1, WORD};
    assign xfer       = in_valid_i & in_ready_o;
    assign last       = (idx_q + CNT_W'(1)) == cnt_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        word_d     = word_q;
        init_val_d = init_val_q;
        init_we_d  = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    state_d = HDR0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    k_d     = '0;
                end
            end
            HDR0: begin
                if (xfer) begin
                    init_val_d = in_data_i;
                    init_we_d  = 1'b1;
                    state_d    = HDR1;
                end
            end
            HDR1: begin
                if (xfer) begin
                    if (in_data_i == '0) begin
                        state_d = DONE;
                    end else if (in_data_i > DATA_W'(DEPTH)) begin
                        state_d = ERR;
                    end else begin
                        cnt_d   = CNT_W'(in_data_i);
                        state_d = WORD;
                    end
                end
            end
            WORD: begin
                if (xfer) begin
                    if (BYTE_MODE != 0) begin
                        word_d  = in_data_i;
                        k_d     = '0;
                        state_d = SPLIT;
                    end else begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = ADDR_W'(idx_q);
                        mem_data_d = in_data_i;
                        idx_d      = idx_q + CNT_W'(1);
                        state_d    = last ? DONE : WORD;
                    end
                end
            end
            SPLIT: begin
                // Little-endian: byte k of the word lands at byte address 4*i+k.
                mem_we_d   = 1'b1;
                mem_addr_d = ADDR_W'({idx_q, k_q});
                mem_data_d = DATA_W'(word_q[{k_q, 3'b000} +: 8]);
                k_d        = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = last ? DONE : WORD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            word_q     <= '0;
            init_val_q <= '0;
            init_we_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            word_q     <= word_d;
            init_val_q <= init_val_d;
            init_we_q  <= init_we_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign init_val_o = init_val_q;
    assign init_we_o  = init_we_q;
    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign busy_o     = state_q inside {HDR0, HDR1, WORD, SPLIT};
    assign done_o     = state_q == DONE;
    assign err_o      = state_q == ERR;
endmodule

// File: tb/tb_image_loader.sv
// Directed bench: one word-mode loader and one byte-mode loader on a shared clock/reset.
module tb_image_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        w_start = 0, w_valid = 0;
    logic [31:0] w_data = 0;
    logic        w_ready, w_init_we, w_we, w_busy, w_done, w_err;
    logic [31:0] w_init_val, w_mdata;
    logic [11:0] w_addr;

    logic        b_start = 0, b_valid = 0;
    logic [31:0] b_data = 0;
    logic        b_ready, b_init_we, b_we, b_busy, b_done, b_err;
    logic [31:0] b_init_val, b_mdata;
    logic [11:0] b_addr;

    image_loader #(.DATA_W(32), .DEPTH(1024), .ADDR_W(12), .BYTE_MODE(0)) u_word (
        .clk_i(clk), .rst_i(rst_n), .start_i(w_start), .in_valid_i(w_valid),
        .in_data_i(w_data), .in_ready_o(w_ready), .init_val_o(w_init_val),
        .init_we_o(w_init_we), .mem_we_o(w_we), .mem_addr_o(w_addr),
        .mem_data_o(w_mdata), .busy_o(w_busy), .done_o(w_done), .err_o(w_err));

    image_loader #(.DATA_W(32), .DEPTH(1024), .ADDR_W(12), .BYTE_MODE(1)) u_byte (
        .clk_i(clk), .rst_i(rst_n), .start_i(b_start), .in_valid_i(b_valid),
        .in_data_i(b_data), .in_ready_o(b_ready), .init_val_o(b_init_val),
        .init_we_o(b_init_we), .mem_we_o(b_we), .mem_addr_o(b_addr),
        .mem_data_o(b_mdata), .busy_o(b_busy), .done_o(b_done), .err_o(b_err));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write logs, appended only by the monitors; the stimulus reads them by base offset.
    logic [11:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          w_init_cnt = 0;
    logic [11:0] ba_q[$];
    logic [31:0] bd_q[$];
    int          bc_q[$];
    logic        br_q[$];

    always @(negedge clk) begin
        if (w_we) begin
            wa_q.push_back(w_addr);
            wd_q.push_back(w_mdata);
        end
        if (w_init_we) w_init_cnt = w_init_cnt + 1;
        if (b_we) begin
            ba_q.push_back(b_addr);
            bd_q.push_back(b_mdata);
            bc_q.push_back(cyc);
            br_q.push_back(b_ready);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input bit sel);
        @(negedge clk);
        if (sel) b_start = 1; else w_start = 1;
        @(negedge clk);
        b_start = 0;
        w_start = 0;
    endtask

    // Present one word and hold it until the loader's ready shows, bounded.
    task automatic send(input bit sel, input logic [31:0] d, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        if (sel) begin b_valid = 1; b_data = d; end
        else begin w_valid = 1; w_data = d; end
        n = 0;
        while (!(sel ? b_ready : w_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("xfer_ready", sel ? b_ready : w_ready, 1);
        @(negedge clk);
        b_valid = 0;
        w_valid = 0;
    endtask

    logic [31:0] exp_d[3];
    int base, ibase;

    initial begin
        exp_d[0] = 32'hA; exp_d[1] = 32'hB; exp_d[2] = 32'hC;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", w_ready, 0);
        chk("rst_busy", w_busy, 0);
        chk("rst_done", w_done, 0);
        chk("rst_err", w_err, 0);
        chk("rst_we", w_we, 0);
        chk("rst_init_val", w_init_val, 0);
        rst_n = 1;
        @(negedge clk);
        chk("idle_ready", w_ready, 0);

        // Word-mode load
        base = wa_q.size(); ibase = w_init_cnt;
        do_start(0);
        chk("hdr0_ready", w_ready, 1);
        chk("hdr0_busy", w_busy, 1);
        send(0, 32'h40, 0);
        send(0, 32'd3, 0);
        send(0, 32'hA, 0);
        send(0, 32'hB, 0);
        send(0, 32'hC, 0);
        repeat (3) @(negedge clk);
        chk("word_init_val", w_init_val, 32'h40);
        chk("word_init_pulses", w_init_cnt - ibase, 1);
        chk("word_nwrites", wa_q.size() - base, 3);
        for (int i = 0; i < 3; i++) begin
            chk("word_addr", wa_q[base + i], i);
            chk("word_data", wd_q[base + i], exp_d[i]);
        end
        chk("word_done", w_done, 1);
        chk("word_busy_after", w_busy, 0);
        chk("word_ready_after", w_ready, 0);

        // Same stream with irregular in_valid gaps
        base = wa_q.size();
        do_start(0);
        chk("restart_clears_done", w_done, 0);
        send(0, 32'h40, $urandom_range(0, 3));
        send(0, 32'd3, $urandom_range(0, 3));
        for (int i = 0; i < 3; i++) send(0, exp_d[i], $urandom_range(0, 4));
        repeat (3) @(negedge clk);
        chk("gap_nwrites", wa_q.size() - base, 3);
        for (int i = 0; i < 3; i++) begin
            chk("gap_addr", wa_q[base + i], i);
            chk("gap_data", wd_q[base + i], exp_d[i]);
        end
        chk("gap_done", w_done, 1);

        // Byte-mode split
        do_start(1);
        send(1, 32'h100, 0);
        send(1, 32'd1, 0);
        send(1, 32'h11223344, 0);
        repeat (8) @(negedge clk);
        chk("byte_init_val", b_init_val, 32'h100);
        chk("byte_nwrites", ba_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("byte_addr", ba_q[k], k);
            chk("byte_data", bd_q[k], (32'h11223344 >> (8 * k)) & 32'hFF);
            chk("byte_consec", bc_q[k] - bc_q[0], k);
            chk("byte_ready_low", br_q[k], 0);
        end
        chk("byte_done", b_done, 1);

        // Count DEPTH+1 -> error, no writes, stream refused
        base = wa_q.size();
        do_start(0);
        send(0, 32'h40, 0);
        send(0, 32'd1025, 0);
        @(negedge clk);
        w_valid = 1; w_data = 32'hDEAD;
        repeat (3) @(negedge clk);
        chk("err_flag", w_err, 1);
        chk("err_ready", w_ready, 0);
        chk("err_busy", w_busy, 0);
        w_valid = 0;
        chk("err_nwrites", wa_q.size() - base, 0);
        do_start(0);
        chk("err_cleared", w_err, 0);

        // Count 0 -> done straight after the header
        send(0, 32'h7, 0);
        send(0, 32'd0, 0);
        @(negedge clk);
        chk("zero_done", w_done, 1);
        chk("zero_init_val", w_init_val, 32'h7);
        chk("zero_nwrites", wa_q.size() - base, 0);

        // Count exactly DEPTH is accepted
        do_start(0);
        send(0, 32'h40, 0);
        send(0, 32'd1024, 0);
        chk("depth_err", w_err, 0);
        chk("depth_ready", w_ready, 1);
        chk("depth_busy", w_busy, 1);

        // Reset in the middle of a load
        do_start(0);
        chk("midrst_restart_ignored", w_busy, 1);
        rst_n = 0; @(negedge clk); rst_n = 1;
        base = wa_q.size();
        do_start(0);
        send(0, 32'h40, 0);
        send(0, 32'd5, 0);
        send(0, 32'hA, 0);
        send(0, 32'hB, 0);
        #1 rst_n = 0;
        #1;
        chk("midrst_we", w_we, 0);
        chk("midrst_addr", w_addr, 0);
        chk("midrst_data", w_mdata, 0);
        chk("midrst_init_val", w_init_val, 0);
        chk("midrst_busy", w_busy, 0);
        chk("midrst_ready", w_ready, 0);
        @(negedge clk);
        rst_n = 1;
        chk("prerst_nwrites", wa_q.size() - base, 2);
        base = wa_q.size();
        repeat (3) @(negedge clk);
        chk("postrst_quiet", wa_q.size() - base, 0);
        do_start(0);
        send(0, 32'h50, 0);
        send(0, 32'd2, 0);
        send(0, 32'hD, 0);
        send(0, 32'hE, 0);
        repeat (3) @(negedge clk);
        chk("reload_nwrites", wa_q.size() - base, 2);
        chk("reload_addr0", wa_q[base], 0);
        chk("reload_data0", wd_q[base], 32'hD);
        chk("reload_addr1", wa_q[base + 1], 1);
        chk("reload_data1", wd_q[base + 1], 32'hE);
        chk("reload_init_val", w_init_val, 32'h50);
        chk("reload_done", w_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, stream and memory data word width.
REQ-002 SHALL have parameter DEPTH, default 1024, maximum payload words accepted.
REQ-003 SHALL have parameter ADDR_W, default 12, memory address width, at least clog2(DEPTH)+2.
REQ-004 SHALL have parameter BYTE_MODE, default 0: 0 = word writes, 1 = four byte writes per word.
REQ-005 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start_i  input  1  begin a load when idle.
REQ-008 SHALL have port in_valid_i  input  1  stream word valid.
REQ-009 SHALL have port in_data_i  input  DATA_W  stream word.
REQ-010 SHALL have port in_ready_o  output  1  loader accepts stream word this cycle.
REQ-011 SHALL have port init_val_o  output  DATA_W  captured header word 0 (initial PC or SP).
REQ-012 SHALL have port init_we_o  output  1  one-cycle pulse when init_val_o updates.
REQ-013 SHALL have port mem_we_o  output  1  memory write strobe.
REQ-014 SHALL have port mem_addr_o  output  ADDR_W  write address (word index, or byte address in BYTE_MODE).
REQ-015 SHALL have port mem_data_o  output  DATA_W  write data (byte zero-extended in BYTE_MODE).
REQ-016 SHALL have ports busy_o, done_o, err_o  output  1 each  status flags.

Function
REQ-017 SHALL implement states IDLE, HDR0, HDR1, WORD, SPLIT, DONE, ERR.
REQ-018 SHALL transfer a stream word only on a rising edge where in_valid_i and in_ready_o are both 1.
REQ-019 SHALL drive in_ready_o high only in HDR0, HDR1 and WORD.
REQ-020 SHALL move IDLE, DONE or ERR to HDR0 on start_i, clearing done_o, err_o and the word index.
REQ-021 SHALL ignore start_i in HDR0, HDR1, WORD and SPLIT.
REQ-022 SHALL, on transfer in HDR0, register the word into init_val_o, pulse init_we_o in the next cycle, and go to HDR1.
REQ-023 SHALL, on transfer in HDR1, latch the word as count N: N=0 goes to DONE, N>DEPTH goes to ERR, otherwise goes to WORD.
REQ-024 SHALL, in word mode on transfer in WORD, assert mem_we_o for exactly the next cycle with mem_addr_o = index i and mem_data_o = the word.
REQ-025 SHALL, in BYTE_MODE on transfer in WORD, enter SPLIT and drop in_ready_o.
REQ-026 SHALL, in SPLIT, emit four consecutive write cycles k=0..3 with mem_addr_o = 4*i+k and mem_data_o = word bits [8k+7:8k] (little-endian), then return to WORD or go to DONE.
REQ-027 SHALL increment index i once per payload word and go to DONE after the write for i = N-1 is issued.
REQ-028 SHALL hold mem_we_o low except on the cycles defined in REQ-024 and REQ-026.
REQ-029 SHALL assert busy_o in HDR0, HDR1, WORD and SPLIT.
REQ-030 SHALL make done_o and err_o sticky until the next accepted start_i.
REQ-031 SHALL discard further stream words in IDLE, DONE and ERR (in_ready_o=0).
REQ-032 SHALL never write at an address at or beyond DEPTH words (DEPTH*4 bytes).

Reset
REQ-033 SHALL, on rst_i low at any time including mid-load, go immediately to IDLE with all outputs and counters at 0.
REQ-034 SHALL not complete or resume any partial write sequence after reset release.

Verification
REQ-035 Word mode, start_i, stream 0x00000040, 3, 0xA, 0xB, 0xC -> init_val_o=0x40 with one init_we_o pulse; writes (0,0xA),(1,0xB),(2,0xC); done_o=1.
REQ-036 BYTE_MODE, stream 0x100, 1, 0x11223344 -> writes (0,0x44),(1,0x33),(2,0x22),(3,0x11) on four consecutive cycles; in_ready_o=0 throughout.
REQ-037 Header count DEPTH+1 -> err_o=1, no mem_we_o, in_ready_o=0; subsequent start_i clears err_o.
REQ-038 Count 0 -> done_o=1 after HDR1, zero writes.
REQ-039 Randomly toggled in_valid_i -> identical write sequence to REQ-035, one write per transfer.
REQ-040 rst_i low after second payload word -> outputs 0 and state IDLE; a new load from start_i writes from index 0.
